// File: rtl/layer_mac_pkg.sv
// Shared definitions for the layer engines: parameter defaults, sequencer
// state encoding and the output saturate/ReLU stage.
package layer_mac_pkg;

  localparam int N_IN_DEF   = 784;
  localparam int N_OUT_DEF  = 16;
  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 28;
  localparam int SHIFT_DEF  = 7;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    WRITE,
    DONE
  } state_t;

  // Address width that never collapses to zero bits for a single-entry memory.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // ReLU plus clamp to the largest positive value representable in data_w bits.
  function automatic logic signed [31:0] relu_sat(input logic signed [63:0] r,
                                                  input int data_w);
    logic signed [63:0] max_pos;
    max_pos = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    if (r < 0)            return '0;
    else if (r > max_pos) return max_pos[31:0];
    else                  return r[31:0];
  endfunction

endpackage

// File: rtl/layer_mac_if.sv
// Controller handshake and memory ports of one layer engine.
interface layer_mac_if
  import layer_mac_pkg::*;
#(
  parameter int N_IN   = N_IN_DEF,
  parameter int N_OUT  = N_OUT_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  localparam int IA = addr_w(N_IN);
  localparam int WA = addr_w(N_IN * N_OUT);
  localparam int OA = addr_w(N_OUT);

  logic                     go;
  logic                     done;
  logic                     busy;
  logic [IA-1:0]            in_addr;
  logic signed [DATA_W-1:0] in_data;
  logic [WA-1:0]            w_addr;
  logic signed [DATA_W-1:0] w_data;
  logic                     out_we;
  logic [OA-1:0]            out_addr;
  logic signed [DATA_W-1:0] out_data;

  modport master (
    input  go, in_data, w_data,
    output done, busy, in_addr, w_addr, out_we, out_addr, out_data
  );

  modport slave (
    output go, in_data, w_data,
    input  done, busy, in_addr, w_addr, out_we, out_addr, out_data
  );

endinterface

// File: rtl/layer_mac_mac_acc.sv
// Multiply-accumulate datapath: full-width signed product, sign-extended
// into a wrapping accumulator with synchronous clear and enable.
module mac_acc
  import layer_mac_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc_next
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc_q;

  assign prod = a * b;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; a missing branch would otherwise infer a latch.
  always_comb begin
    acc_next = acc_q;
    if (clr)     acc_next = '0;
    else if (en) acc_next = acc_q + ACC_W'(prod);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_next;
  end

endmodule

// File: rtl/layer_mac.sv
// Fully-connected layer sequencer: walks every (j, i) pair, streams operands
// from synchronous memories into mac_acc and writes one clamped result per j.
module layer_mac
  import layer_mac_pkg::*;
#(
  parameter int N_IN   = N_IN_DEF,
  parameter int N_OUT  = N_OUT_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int SHIFT  = SHIFT_DEF
) (
  input logic       clk,
  input logic       reset,
  layer_mac_if.master bus
);

  localparam int IA = addr_w(N_IN);
  localparam int WA = addr_w(N_IN * N_OUT);
  localparam int OA = addr_w(N_OUT);

  state_t                   state_q, state_d;
  logic [IA-1:0]            i_q, i_d, in_addr_q;
  logic [OA-1:0]            j_q, j_d;
  logic [WA-1:0]            w_addr_q, w_addr_run;
  logic                     acc_clr;
  logic                     rd_valid_q;
  logic signed [ACC_W-1:0]  acc_next;
  logic signed [63:0]       shifted;
  logic signed [DATA_W-1:0] result;
  logic                     out_we_q;
  logic [OA-1:0]            out_addr_q;
  logic signed [DATA_W-1:0] out_data_q;

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    acc_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.go) begin
          i_d     = '0;
          j_d     = '0;
          acc_clr = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (i_q == IA'(N_IN - 1)) state_d = DRAIN;
        else                      i_d     = i_q + IA'(1);
      end
      DRAIN: state_d = WRITE;
      WRITE: begin
        acc_clr = 1'b1;
        i_d     = '0;
        if (j_q == OA'(N_OUT - 1)) begin
          state_d = DONE;
        end else begin
          j_d     = j_q + OA'(1);
          state_d = RUN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      i_q        <= '0;
      j_q        <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      rd_valid_q <= (state_q == RUN);
    end
  end

  // Addresses follow the counters during RUN and freeze on the last one shown.
  assign w_addr_run  = WA'(j_q) * WA'(N_IN) + WA'(i_q);
  assign bus.in_addr = (state_q == RUN) ? i_q : in_addr_q;
  assign bus.w_addr  = (state_q == RUN) ? w_addr_run : w_addr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      in_addr_q <= '0;
      w_addr_q  <= '0;
    end else if (state_q == RUN) begin
      in_addr_q <= i_q;
      w_addr_q  <= w_addr_run;
    end
  end

  mac_acc #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac_acc (
    .clk      (clk),
    .reset    (reset),
    .clr      (acc_clr),
    .en       (rd_valid_q),
    .a        (bus.in_data),
    .b        (bus.w_data),
    .acc_next (acc_next)
  );

  // The last product lands on the DRAIN->WRITE edge, so the registered result
  // is formed from the accumulator's next value.
  assign shifted = 64'(acc_next) >>> SHIFT;
  assign result  = DATA_W'(relu_sat(shifted, DATA_W));

  always_ff @(posedge clk) begin
    if (reset) begin
      out_we_q   <= 1'b0;
      out_addr_q <= '0;
      out_data_q <= '0;
    end else begin
      out_we_q   <= (state_d == WRITE);
      out_addr_q <= (state_d == WRITE) ? j_q : '0;
      out_data_q <= (state_d == WRITE) ? result : '0;
    end
  end

  assign bus.out_we   = out_we_q;
  assign bus.out_addr = out_addr_q;
  assign bus.out_data = out_data_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = (state_q == DONE);

endmodule

// File: tb/tb_layer_mac.sv
// Randomized bench for layer_mac with synchronous memory models and a
// dot-product/ReLU/clamp reference computed from the memory contents.
module tb_layer_mac;
  import layer_mac_pkg::*;

  localparam int N_IN   = 4;
  localparam int N_OUT  = 2;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 20;
  localparam int SHIFT  = 0;
  localparam int LAT    = N_OUT * (N_IN + 2) + 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  layer_mac_if #(.N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(DATA_W)) bus ();

  layer_mac #(
    .N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(DATA_W), .ACC_W(ACC_W), .SHIFT(SHIFT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic signed [DATA_W-1:0] in_mem [N_IN];
  logic signed [DATA_W-1:0] w_mem  [N_IN*N_OUT];

  always @(posedge clk) begin
    bus.in_data <= in_mem[bus.in_addr];
    bus.w_data  <= w_mem[bus.w_addr];
  end

  int wr_addr_q[$];
  int wr_data_q[$];
  int done_cnt      = 0;
  int idle_data_bad = 0;

  always @(negedge clk) begin
    if (cyc > 0) begin
      if (bus.out_we === 1'b1) begin
        wr_addr_q.push_back(int'(bus.out_addr));
        wr_data_q.push_back(int'(bus.out_data));
      end else if (bus.out_data !== '0) begin
        idle_data_bad++;
      end
      if (bus.done === 1'b1) done_cnt++;
    end
  end

  function automatic int model_out(input int j);
    longint s = 0;
    longint max_pos = (64'sd1 <<< (DATA_W - 1)) - 1;
    for (int i = 0; i < N_IN; i++) s += longint'(in_mem[i]) * longint'(w_mem[j*N_IN + i]);
    s = s >>> SHIFT;
    if (s < 0) return 0;
    if (s > max_pos) return int'(max_pos);
    return int'(s);
  endfunction

  task automatic fill_const(input int in_v, input int w_v);
    for (int i = 0; i < N_IN; i++) in_mem[i] = DATA_W'(in_v);
    for (int k = 0; k < N_IN*N_OUT; k++) w_mem[k] = DATA_W'(w_v);
  endtask

  task automatic fill_rand(input int lo, input int hi);
    int v;
    for (int i = 0; i < N_IN; i++) begin
      v = lo + int'($urandom_range(0, hi - lo));
      in_mem[i] = DATA_W'(v);
    end
    for (int k = 0; k < N_IN*N_OUT; k++) begin
      v = lo + int'($urandom_range(0, hi - lo));
      w_mem[k] = DATA_W'(v);
    end
  endtask

  // go is raised for the cycle numbered go_at; the DUT samples it at the next edge.
  task automatic pulse_go(output int go_at);
    @(negedge clk);
    bus.go = 1'b1;
    go_at  = cyc;
    @(negedge clk);
    bus.go = 1'b0;
  endtask

  task automatic wait_done(input int go_at, output int lat);
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      if (bus.done === 1'b1) begin
        lat = cyc - go_at;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_layer(input string name);
    int g, lat;
    wr_addr_q.delete();
    wr_data_q.delete();
    pulse_go(g);
    wait_done(g, lat);
    n_tests++;
    if (lat !== LAT) begin
      n_fail++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, LAT);
    end
    repeat (2) @(negedge clk);
    n_tests++;
    if (wr_addr_q.size() != N_OUT) begin
      n_fail++;
      $display("FAIL %s write count: got %0d want %0d", name, wr_addr_q.size(), N_OUT);
    end
    for (int j = 0; j < N_OUT && j < wr_addr_q.size(); j++) begin
      n_tests++;
      if (wr_addr_q[j] !== j || wr_data_q[j] !== model_out(j)) begin
        n_fail++;
        $display("FAIL %s write %0d: got addr %0d data %0d want addr %0d data %0d",
                 name, j, wr_addr_q[j], wr_data_q[j], j, model_out(j));
      end
    end
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    bus.go = 1'b1;
    fill_const(0, 0);
    repeat (3) @(negedge clk);
    n_tests++;
    if ({bus.done, bus.busy, bus.out_we} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset flags: got done/busy/we %b%b%b want 000", bus.done, bus.busy, bus.out_we);
    end
    n_tests++;
    if (bus.out_addr !== '0 || bus.out_data !== '0) begin
      n_fail++;
      $display("FAIL reset out: got addr %0d data %0d want 0 0", bus.out_addr, bus.out_data);
    end
    n_tests++;
    if (bus.in_addr !== '0 || bus.w_addr !== '0) begin
      n_fail++;
      $display("FAIL reset addr: got in %0d w %0d want 0 0", bus.in_addr, bus.w_addr);
    end
    bus.go = 1'b0;
    reset  = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset idle busy: got %b want 0", bus.busy);
    end
  endtask

  task automatic test_basic();
    fill_const(1, 1);
    run_layer("basic");
  endtask

  task automatic test_relu();
    fill_const(1, -1);
    run_layer("relu");
  endtask

  task automatic test_saturation();
    fill_const(127, 127);
    run_layer("saturation");
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      if (r < 4) fill_rand(-5, 5);
      else       fill_rand(-128, 127);
      run_layer($sformatf("random%0d", r));
    end
  endtask

  task automatic test_ignored_go();
    int c, base;
    fill_const(1, 1);
    wr_addr_q.delete();
    wr_data_q.delete();
    base = done_cnt;
    pulse_go(c);
    while (cyc < c + 3) @(negedge clk);
    bus.go = 1'b1;
    @(negedge clk);
    bus.go = 1'b0;
    while (cyc < c + 13) @(negedge clk);
    n_tests++;
    if (bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL ignored_go done cycle: got %b want 1", bus.done);
    end
    bus.go = 1'b1;
    @(negedge clk);
    bus.go = 1'b0;
    n_tests++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ignored_go restart: got busy %b want 0", bus.busy);
    end
    repeat (20) @(negedge clk);
    n_tests++;
    if (wr_addr_q.size() != 2 || done_cnt - base != 1) begin
      n_fail++;
      $display("FAIL ignored_go counts: got writes %0d dones %0d want 2 1",
               wr_addr_q.size(), done_cnt - base);
    end
    for (int j = 0; j < wr_data_q.size() && j < N_OUT; j++) begin
      n_tests++;
      if (wr_addr_q[j] !== j || wr_data_q[j] !== model_out(j)) begin
        n_fail++;
        $display("FAIL ignored_go write %0d: got addr %0d data %0d want addr %0d data %0d",
                 j, wr_addr_q[j], wr_data_q[j], j, model_out(j));
      end
    end
  endtask

  task automatic test_mid_reset();
    int c, base;
    fill_rand(-5, 5);
    wr_addr_q.delete();
    wr_data_q.delete();
    base = done_cnt;
    pulse_go(c);
    while (cyc < c + 5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.in_addr !== '0 || bus.w_addr !== '0) begin
      n_fail++;
      $display("FAIL mid_reset state: got busy %b in %0d w %0d want 0 0 0",
               bus.busy, bus.in_addr, bus.w_addr);
    end
    repeat (20) @(negedge clk);
    n_tests++;
    if (wr_addr_q.size() != 0 || done_cnt != base) begin
      n_fail++;
      $display("FAIL mid_reset abort: got writes %0d dones %0d want 0 0",
               wr_addr_q.size(), done_cnt - base);
    end
    run_layer("mid_reset_rerun");
  endtask

  task automatic test_idle_data();
    n_tests++;
    if (idle_data_bad != 0) begin
      n_fail++;
      $display("FAIL idle out_data: got %0d nonzero samples want 0", idle_data_bad);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_relu();
    test_saturation();
    test_random();
    test_ignored_go();
    test_mid_reset();
    test_idle_data();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/layer_mac.md
LAYER_MAC -- requirements
Module: layer_mac

Interface
REQ-001 Parameter N_IN, default 784, SHALL set the number of input activations per output neuron.
REQ-002 Parameter N_OUT, default 16, SHALL set the number of output neurons computed per go.
REQ-003 Parameter DATA_W, default 8, SHALL set the signed width of activations, weights and results.
REQ-004 Parameter ACC_W, default 28, SHALL set the accumulator width, with ACC_W >= 2*DATA_W + clog2(N_IN).
REQ-005 Parameter SHIFT, default 7, SHALL set the arithmetic right shift applied before output.
REQ-006 clk  in  1  clock; all logic SHALL be on the rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 go  in  1  one-cycle start pulse from the layer controller.
REQ-009 done  out  1  one-cycle completion pulse to the layer controller.
REQ-010 busy  out  1  high in every state other than IDLE.
REQ-011 in_addr  out  clog2(N_IN)  input-activation memory read address.
REQ-012 in_data  in  DATA_W  signed activation, valid 1 cycle after in_addr.
REQ-013 w_addr  out  clog2(N_IN*N_OUT)  weight memory read address, equal to j*N_IN+i.
REQ-014 w_data  in  DATA_W  signed weight, valid 1 cycle after w_addr.
REQ-015 out_we  out  1  result write strobe.
REQ-016 out_addr  out  clog2(N_OUT)  result index j.
REQ-017 out_data  out  DATA_W  signed result, valid while out_we is high.

Function
REQ-018 The FSM SHALL have the states IDLE, RUN, DRAIN, WRITE and DONE.
REQ-019 In IDLE, go=1 SHALL clear i, j and acc, and move the FSM to RUN; go=0 SHALL hold IDLE.
REQ-020 RUN SHALL last exactly N_IN cycles, presenting i=0..N_IN-1 on in_addr/w_addr, one address per cycle.
REQ-021 A read-valid flag SHALL be a 1-cycle delay of (state==RUN), and acc SHALL add sext(in_data*w_data) only when that flag is high.
REQ-022 RUN with i==N_IN-1 SHALL go to DRAIN, where the last product is accumulated.
REQ-023 DRAIN SHALL always go to WRITE.
REQ-024 In WRITE, out_we=1 and out_addr=j for exactly one cycle.
REQ-025 In WRITE, out_data SHALL be r = acc>>>SHIFT, forced to 0 if r<0 and to 2^(DATA_W-1)-1 if r exceeds it.
REQ-026 WRITE SHALL clear acc and i; if j==N_OUT-1 the next state is DONE, otherwise j increments and the next state is RUN.
REQ-027 DONE SHALL assert done=1 for one cycle, then return to IDLE.
REQ-028 Latency: if go is sampled at edge E0, done SHALL be high in cycle E0 + N_OUT*(N_IN+2) + 1.
REQ-029 go SHALL be ignored in every state other than IDLE, including DONE: no restart and no change to counters.
REQ-030 The product SHALL be the full 2*DATA_W signed result, sign-extended to ACC_W; accumulation wraps modulo 2^ACC_W, and REQ-004 precludes overflow.
REQ-031 out_we, out_addr and out_data SHALL be registered; out_data SHALL be 0 whenever out_we=0.
REQ-032 in_addr and w_addr SHALL hold their last value outside RUN.

Reset
REQ-033 reset SHALL force the state to IDLE and clear i, j, acc and the read-valid flag to 0, overriding go in the same cycle.
REQ-034 During and after reset, done, busy, out_we, out_addr, out_data, in_addr and w_addr SHALL all read 0.
REQ-035 A reset mid-operation SHALL abort the layer with no further out_we and no done; the next go SHALL start a full run from j=0.

Structure
REQ-036 A shared package SHALL hold the state enum, the parameter defaults, and a saturate/ReLU function used by every layer engine.
REQ-037 The multiply-accumulate datapath (product, sign-extend, acc register, clear/enable) SHALL be a sub-module named mac_acc; sequencing SHALL stay in layer_mac.

Verification
Bench parameters: N_IN=4, N_OUT=2, DATA_W=8, SHIFT=0. Memories are synchronous, 1-cycle latency.
REQ-038 Reset check: hold reset 3 cycles -> all outputs 0; busy=0.
REQ-039 Basic run: all in=1, w=1, go pulse -> out_we at j=0 and j=1 with out_data=4 each; done exactly 13 cycles after the go edge.
REQ-040 ReLU: in=1, w=-1 -> out_data=0 for both neurons.
REQ-041 Saturation: in=127, w=127 (acc=64516) -> out_data=127.
REQ-042 Ignored go: go pulses on cycles 3 and 13 (the DONE cycle) -> exactly 2 writes, one done, then IDLE.
REQ-043 Mid-run reset: reset asserted at cycle 5 after go -> no out_we, no done; a new go -> a full correct run of 13 cycles.
